// File: rtl/spi_quad_host.sv
// spi_quad_host: quad-SPI initiator serializing one register request per frame onto CS_N/SCK/COPI/CIPO
module spi_quad_host #(
    parameter int CLK_DIV  = 2,
    parameter int TURN_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        CS_N,
    output logic        SCK,
    output logic [3:0]  COPI,
    input  logic [3:0]  CIPO
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    typedef enum logic [3:0] {IDLE, SETUP, CMD, ADDR, TURN, DATA, HOLD, DONE, GAP} state_t;
    state_t st, ns;
    logic [DW-1:0] div_cnt;
    logic [3:0] nib, dn;
    logic [47:0] sr;
    logic [31:0] rx, wdata_lj;
    logic [1:0] sz;
    logic wr, tick, last_nib;
    always_comb begin
        tick = div_cnt == DW'(CLK_DIV - 1);
        dn = sz == 2'd0 ? 4'd2 : sz == 2'd1 ? 4'd4 : 4'd8;
        last_nib = nib == (st == TURN ? 4'(TURN_CYC - 1) : st == DATA ? dn - 4'd1 : 4'd1);
        ns = !last_nib ? st : st == CMD ? ADDR : st == ADDR ? (wr ? DATA : TURN) : st == TURN ? DATA : HOLD;
        wdata_lj = req_size == 2'd0 ? {req_wdata[7:0], 24'd0} :
                   req_size == 2'd1 ? {req_wdata[15:0], 16'd0} : req_wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            div_cnt   <= '0;
            nib       <= '0;
            sr        <= '0;
            rx        <= '0;
            sz        <= '0;
            wr        <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            CS_N      <= 1'b1;
            SCK       <= 1'b0;
            COPI      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            div_cnt   <= (tick || st == IDLE || st == DONE) ? '0 : div_cnt + 1'b1;
            case (st)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        st        <= SETUP;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        CS_N      <= 1'b0;
                        wr        <= req_write;
                        sz        <= req_size;
                        rx        <= '0;
                        nib       <= '0;
                        sr        <= {~req_write, 5'd0, req_size, req_addr, wdata_lj};
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: if (tick) begin
                    st   <= CMD;
                    COPI <= sr[47:44];
                end
                CMD, ADDR, TURN, DATA: if (tick) begin
                    SCK <= ~SCK;
                    if (!SCK) begin
                        if (st == DATA) rx <= {rx[27:0], CIPO};
                    end else begin
                        sr   <= sr << 4;
                        st   <= ns;
                        nib  <= last_nib ? 4'd0 : nib + 4'd1;
                        COPI <= (ns == CMD || ns == ADDR || (ns == DATA && wr)) ? sr[43:40] : 4'd0;
                    end
                end
                HOLD: if (tick) begin
                    st        <= DONE;
                    CS_N      <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= wr ? '0 : rx;
                end
                DONE: begin
                    st   <= GAP;
                    busy <= 1'b0;
                end
                GAP: if (tick) begin
                    st        <= IDLE;
                    req_ready <= 1'b1;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_quad_host.sv
// tb_spi_quad_host: randomized scoreboard bench with a behavioural quad-SPI responder
module tb_spi_quad_host;
    localparam int CD = 2;
    localparam int TC = 2;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    logic req_valid = 0, req_ready, req_write = 0;
    logic [1:0] req_size = 0;
    logic [7:0] req_addr = 0;
    logic [31:0] req_wdata = 0, rsp_rdata;
    logic rsp_valid, busy, CS_N, SCK;
    logic [3:0] COPI, CIPO = 0;
    int vectors = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc++;

    spi_quad_host #(.CLK_DIV(CD), .TURN_CYC(TC)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .CS_N(CS_N), .SCK(SCK), .COPI(COPI), .CIPO(CIPO));

    typedef struct {logic [31:0] rd; int acc; int lat;} rsp_t;
    typedef struct {int n; logic [63:0] bits;} frm_t;
    rsp_t rq[$];
    frm_t fq[$];
    logic [31:0] exp_mem[256], mem[256];

    function automatic int dnib(logic [1:0] s);
        return s == 2'd0 ? 2 : s == 2'd1 ? 4 : 8;
    endfunction
    function automatic logic [31:0] msk(logic [1:0] s);
        return s == 2'd0 ? 32'hFF : s == 2'd1 ? 32'hFFFF : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Drive one request; when tracked, push the expected response and the expected COPI frame.
    task automatic issue(bit w, logic [1:0] s, logic [7:0] a, logic [31:0] d, bit keep, bit track);
        int n = 0;
        int dn = dnib(s);
        rsp_t r;
        frm_t f;
        @(posedge clk); #1;
        req_write = w; req_size = s; req_addr = a; req_wdata = d; req_valid = 1;
        @(negedge clk);
        while (!req_ready && n < 2000) begin @(negedge clk); n++; end
        if (!req_ready) begin
            vectors++; errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1");
        end else if (track) begin
            r.acc = cyc;
            r.lat = CD * (2 + 2 * (4 + dn + (w ? 0 : TC))) + 1;
            r.rd  = w ? 32'd0 : exp_mem[a] & msk(s);
            rq.push_back(r);
            f.n    = 4 + dn + (w ? 0 : TC);
            f.bits = 64'({~w, 5'd0, s, a});
            f.bits = w ? (f.bits << (4 * dn)) | 64'(d & msk(s)) : f.bits << (4 * (TC + dn));
            fq.push_back(f);
            if (w) exp_mem[a] = d & msk(s);
        end
        @(posedge clk); #1;
        req_write = 1'($urandom); req_size = 2'($urandom); req_addr = 8'($urandom);
        req_wdata = $urandom; req_valid = keep;
    endtask

    int cnt = 0, dnr = 2, rise_cyc = -1;
    logic [63:0] got = 0;
    logic [31:0] rdv = 0;
    logic [7:0] cm, ad;
    logic pcs = 1, psck = 0, rdf = 0;
    frm_t fe;
    always @(SCK or CS_N) begin
        if (CS_N !== pcs) begin
            if (!CS_N) begin
                cnt = 0; got = 0; rdf = 0;
                if (rise_cyc >= 0) begin
                    vectors++;
                    if (cyc - rise_cyc < CD + 1) begin
                        errors++;
                        $display("FAIL cs_gap: got %0d clks expected >= %0d", cyc - rise_cyc, CD + 1);
                    end
                end
            end else if (rst_n) begin
                rise_cyc = cyc;
                vectors++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected: got %0d nibbles expected none", cnt);
                end else begin
                    fe = fq.pop_front();
                    if (cnt != fe.n || got !== fe.bits) begin
                        errors++;
                        $display("FAIL frame: got %0d nibbles %h expected %0d nibbles %h", cnt, got, fe.n, fe.bits);
                    end
                end
                if (cnt >= 4) begin
                    cm = 8'(got >> (4 * (cnt - 2)));
                    ad = 8'(got >> (4 * (cnt - 4)));
                    if (!cm[7] && cnt == 4 + dnib(cm[1:0])) mem[ad] = 32'(got) & msk(cm[1:0]);
                end
            end else begin
                rise_cyc = -1;
            end
        end else if (!CS_N && SCK && !psck) begin
            got = {got[59:0], COPI};
            cnt++;
            if (cnt == 4) begin
                rdf = got[15];
                dnr = dnib(got[9:8]);
                rdv = mem[got[7:0]] & msk(got[9:8]);
            end
        end else if (!CS_N && !SCK && psck) begin
            CIPO = (rdf && cnt >= 4 + TC && cnt < 4 + TC + dnr) ? rdv[4 * (dnr - 1 - (cnt - 4 - TC)) +: 4] : 4'($urandom);
        end
        pcs = CS_N; psck = SCK;
    end

    rsp_t mr;
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (rq.size() == 0) begin
                vectors++; errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0");
            end else begin
                mr = rq.pop_front();
                chk("rsp_rdata", rsp_rdata, mr.rd);
                chk("latency", cyc - mr.acc, mr.lat);
                chk("busy_at_rsp", 32'(busy), 32'd1);
            end
        end
    end

    bit var_go = 0;
    int var_done = 0;
    for (genvar g = 0; g < 2; g++) begin : gv
        localparam int D = g == 0 ? 1 : 4;
        logic v = 0, rdy, rv, bz, cs, sc;
        logic [3:0] co, ci = 0;
        logic [31:0] rd;
        int k = 0, t1 = 0, t2 = 0;
        spi_quad_host #(.CLK_DIV(D), .TURN_CYC(TC)) u_var (
            .clk(clk), .rst_n(rst_n), .req_valid(v), .req_ready(rdy),
            .req_write(1'b0), .req_size(2'd0), .req_addr(8'd0), .req_wdata(32'd0),
            .rsp_valid(rv), .rsp_rdata(rd), .busy(bz),
            .CS_N(cs), .SCK(sc), .COPI(co), .CIPO(ci));
        always @(posedge sc or negedge cs) begin
            if (sc) begin
                k++;
                if (k == 1) t1 = cyc;
                if (k == 2) t2 = cyc;
            end else begin
                k = 0;
            end
        end
        always @(negedge sc) ci = (k == 4 + TC || k == 5 + TC) ? 4'h5 : 4'($urandom);
        initial begin
            int n = 0, a = 0;
            wait (var_go);
            @(posedge clk); #1 v = 1;
            @(negedge clk);
            while (!rdy && n < 100) begin @(negedge clk); n++; end
            a = cyc;
            @(posedge clk); #1 v = 0;
            n = 0;
            while (!rv && n < 400) begin @(negedge clk); n++; end
            chk($sformatf("div%0d_rdata", D), rd, 32'h55);
            chk($sformatf("div%0d_latency", D), cyc - a, 18 * D + 1);
            chk($sformatf("div%0d_sck_period", D), t2 - t1, 2 * D);
            var_done++;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = $urandom;
            mem[i] = exp_mem[i];
        end
        exp_mem[0] = 32'h55; mem[0] = 32'h55;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(CS_N), 32'd1);
        chk("rst_sck", 32'(SCK), 32'd0);
        chk("rst_copi", 32'(COPI), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        issue(1'b0, 2'd0, 8'd0, 32'd0, 1'b0, 1'b1);
        issue(1'b1, 2'd1, 8'd14, 32'd789, 1'b0, 1'b1);
        issue(1'b1, 2'd2, 8'd112, 32'hAAAAAA, 1'b0, 1'b1);
        issue(1'b0, 2'd2, 8'd112, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) issue(1'b1, 2'd1, 8'(20 + 2 * i), 32'(32'h5AA + i), i < 7, 1'b1);
        for (int i = 0; i < 8; i++) issue(1'b0, 2'd1, 8'(20 + 2 * i), 32'd0, 1'b0, 1'b1);
        repeat (40) issue(1'($urandom), 2'($urandom), 8'($urandom_range(0, 15)), $urandom, 1'($urandom), 1'b1);
        issue(1'b1, 2'd2, 8'h40, 32'hDEADBEEF, 1'b0, 1'b0);
        n = 0;
        while (cnt < 6 && n < 500) begin @(negedge clk); n++; end
        chk("abort_reach_data", 32'(cnt >= 6), 32'd1);
        rst_n = 0;
        #1;
        chk("abort_cs_n", 32'(CS_N), 32'd1);
        chk("abort_sck", 32'(SCK), 32'd0);
        chk("abort_copi", 32'(COPI), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        issue(1'b0, 2'd2, 8'h40, 32'd0, 1'b0, 1'b1);
        issue(1'b0, 2'd0, 8'd14, 32'd0, 1'b0, 1'b1);
        n = 0;
        while ((rq.size() != 0 || fq.size() != 0) && n < 2000) begin @(negedge clk); n++; end
        chk("drain_pending", 32'(rq.size() + fq.size()), 32'd0);
        var_go = 1;
        n = 0;
        while (var_done < 2 && n < 2000) begin @(negedge clk); n++; end
        chk("variants_done", 32'(var_done), 32'd2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
